// File: rtl/mtrap_csr.sv
// -----------------------------------------------------------------------------
// mtrap_csr - machine-mode trap CSR unit
//
// Holds mstatus, mie, mip, mtvec, mepc, mcause and mscratch. Responds to the
// trap handler's entry (intr_happen / ex_happen) and return (trap_fin, mret)
// pulses by updating the trap state and issuing a one-cycle PC redirect.
//
// Ports
//   clk, reset            clock, synchronous active-high reset
//   intr_happen/ex_happen trap-entry pulses (interrupt / exception)
//   trap_cause, trap_pc   cause and PC captured on trap entry
//   trap_fin              mret committed
//   ext_irq, time_pending, soft_pending  interrupt levels -> mip[11]/[7]/[3]
//   csr_re, csr_op, csr_addr, csr_wdata  CSR access (op: none/write/set/clear)
//   csr_rdata, csr_illegal               registered read data / bad-address pulse
//   mstatus, mie, mip                    live register values to the trap handler
//   redirect_valid, redirect_pc          one-cycle PC redirect, target held
//   trap_active                          1 while in the HANDLER state
// -----------------------------------------------------------------------------
module mtrap_csr #(
    parameter logic [31:0] MTVEC_RESET = 32'h0000_0000,
    parameter bit          VECTORED_EN = 1'b1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        intr_happen,
    input  logic        ex_happen,
    input  logic [31:0] trap_cause,
    input  logic [31:0] trap_pc,
    input  logic        trap_fin,
    input  logic        ext_irq,
    input  logic        time_pending,
    input  logic        soft_pending,
    input  logic        csr_re,
    input  logic [1:0]  csr_op,
    input  logic [11:0] csr_addr,
    input  logic [31:0] csr_wdata,
    output logic [31:0] csr_rdata,
    output logic        csr_illegal,
    output logic [31:0] mstatus,
    output logic [31:0] mie,
    output logic [31:0] mip,
    output logic        redirect_valid,
    output logic [31:0] redirect_pc,
    output logic        trap_active
);

    localparam logic [11:0] ADDR_MSTATUS  = 12'h300;
    localparam logic [11:0] ADDR_MIE      = 12'h304;
    localparam logic [11:0] ADDR_MTVEC    = 12'h305;
    localparam logic [11:0] ADDR_MSCRATCH = 12'h340;
    localparam logic [11:0] ADDR_MEPC     = 12'h341;
    localparam logic [11:0] ADDR_MCAUSE   = 12'h342;
    localparam logic [11:0] ADDR_MIP      = 12'h344;

    localparam logic [1:0] OP_NONE  = 2'b00;
    localparam logic [1:0] OP_WRITE = 2'b01;
    localparam logic [1:0] OP_SET   = 2'b10;
    localparam logic [1:0] OP_CLEAR = 2'b11;

    localparam logic [31:0] MIE_MASK = 32'h0000_0888;

    typedef enum logic {
        RUN     = 1'b0,
        HANDLER = 1'b1
    } state_t;

    // Illegal mtvec modes collapse to direct mode; the base is kept.
    function automatic logic [31:0] legal_mtvec(input logic [31:0] v);
        if (v[1:0] == 2'b00 || (v[1:0] == 2'b01 && VECTORED_EN))
            return v;
        else
            return {v[31:2], 2'b00};
    endfunction

    state_t      state;
    logic        st_mie;
    logic        st_mpie;
    logic [31:0] mie_q;
    logic [31:0] mtvec_q;
    logic [31:0] mscratch_q;
    logic [31:0] mepc_q;
    logic [31:0] mcause_q;
    logic        ext_q;
    logic        tim_q;
    logic        sw_q;

    logic [31:0] rd_val;
    logic        addr_ok;
    logic        req;
    logic        wr_en;
    logic [31:0] wr_val;
    logic        trap_take;
    logic [31:0] trap_tgt;

    // MPP is hardwired to machine mode; only MIE and MPIE are state.
    assign mstatus     = {19'b0, 2'b11, 3'b0, st_mpie, 3'b0, st_mie, 3'b0};
    assign mie         = mie_q;
    assign mip         = {20'b0, ext_q, 3'b0, tim_q, 3'b0, sw_q, 3'b0};
    assign trap_active = (state == HANDLER);

    always_comb begin
        // NOTE: every variable gets a default first so no path leaves it
        // unassigned, which would infer a latch.
        rd_val    = 32'h0;
        addr_ok   = 1'b1;
        wr_val    = csr_wdata;
        trap_tgt  = {mtvec_q[31:2], 2'b00};

        case (csr_addr)
            ADDR_MSTATUS:  rd_val = mstatus;
            ADDR_MIE:      rd_val = mie_q;
            ADDR_MTVEC:    rd_val = mtvec_q;
            ADDR_MSCRATCH: rd_val = mscratch_q;
            ADDR_MEPC:     rd_val = mepc_q;
            ADDR_MCAUSE:   rd_val = mcause_q;
            ADDR_MIP:      rd_val = mip;
            default:       addr_ok = 1'b0;
        endcase

        req   = csr_re | (csr_op != OP_NONE);
        wr_en = (csr_op != OP_NONE) & addr_ok;

        case (csr_op)
            OP_WRITE: wr_val = csr_wdata;
            OP_SET:   wr_val = rd_val | csr_wdata;
            OP_CLEAR: wr_val = rd_val & ~csr_wdata;
            default:  wr_val = csr_wdata;
        endcase

        trap_take = intr_happen | ex_happen;

        // Vectored dispatch only for interrupts; exceptions use the base.
        if (mtvec_q[1:0] == 2'b01 && trap_cause[31])
            trap_tgt = {mtvec_q[31:2], 2'b00} + {25'b0, trap_cause[4:0], 2'b00};
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    always_ff @(posedge clk) begin
        if (reset) begin
            state          <= RUN;
            st_mie         <= 1'b0;
            st_mpie        <= 1'b0;
            mie_q          <= 32'h0;
            mtvec_q        <= legal_mtvec(MTVEC_RESET);
            mscratch_q     <= 32'h0;
            mepc_q         <= 32'h0;
            mcause_q       <= 32'h0;
            ext_q          <= 1'b0;
            tim_q          <= 1'b0;
            sw_q           <= 1'b0;
            csr_rdata      <= 32'h0;
            csr_illegal    <= 1'b0;
            redirect_valid <= 1'b0;
            redirect_pc    <= 32'h0;
        end else begin
            ext_q          <= ext_irq;
            tim_q          <= time_pending;
            sw_q           <= soft_pending;
            redirect_valid <= 1'b0;
            csr_illegal    <= req & ~addr_ok;

            // Reads always see the pre-update register values.
            if (req && !addr_ok)
                csr_rdata <= 32'h0;
            else if (csr_re)
                csr_rdata <= rd_val;

            if (trap_take) begin
                // Trap entry swallows any concurrent mret and CSR write.
                mepc_q         <= {trap_pc[31:2], 2'b00};
                mcause_q       <= trap_cause;
                st_mpie        <= st_mie;
                st_mie         <= 1'b0;
                state          <= HANDLER;
                redirect_valid <= 1'b1;
                redirect_pc    <= trap_tgt;
            end else begin
                if (trap_fin) begin
                    st_mie         <= st_mpie;
                    st_mpie        <= 1'b1;
                    state          <= RUN;
                    redirect_valid <= 1'b1;
                    redirect_pc    <= mepc_q;
                end

                if (wr_en) begin
                    case (csr_addr)
                        ADDR_MSTATUS: begin
                            // mret owns mstatus this cycle.
                            if (!trap_fin) begin
                                st_mie  <= wr_val[3];
                                st_mpie <= wr_val[7];
                            end
                        end
                        ADDR_MIE:      mie_q      <= wr_val & MIE_MASK;
                        ADDR_MTVEC:    mtvec_q    <= legal_mtvec(wr_val);
                        ADDR_MSCRATCH: mscratch_q <= wr_val;
                        ADDR_MEPC:     mepc_q     <= {wr_val[31:2], 2'b00};
                        ADDR_MCAUSE:   mcause_q   <= wr_val;
                        default:       ; // mip is read-only
                    endcase
                end
            end
        end
    end

endmodule
